amci_axi4lite_master: RTL and testbench

// AXI4-Lite master engine that sits directly downstream of an AMCI controller.
// - Consumes AMCI_MOSI: address, data and a one-cycle command pulse.
// - Runs the AXI4-Lite write or read transaction on M_AXI_*.
// - Returns idle flags, response codes and read data on AMCI_MISO.
// - Write and read channels are independent and may be busy at the same time.
//

---
 rtl/amci_axi4lite_master.sv | 190 +++++++++++++++++++
 tb/tb_amci_axi4lite_master.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amci_axi4lite_master.sv
// AXI4-Lite master engine driven by an AMCI command bus.
// Independent write and read FSMs run the AXI4-Lite handshakes and report idle/resp/rdata back.
module amci_axi4lite_master #(
  parameter int unsigned AXI_DATA_WIDTH = 32,
  parameter int unsigned AXI_ADDR_WIDTH = 32
) (
  input  logic                                         CLK,
  input  logic                                         RESETN,
  input  logic [2*AXI_ADDR_WIDTH+AXI_DATA_WIDTH+1:0]   AMCI_MOSI,
  output logic [AXI_DATA_WIDTH+5:0]                    AMCI_MISO,
  output logic [AXI_ADDR_WIDTH-1:0]                    M_AXI_AWADDR,
  output logic [2:0]                                   M_AXI_AWPROT,
  output logic                                         M_AXI_AWVALID,
  input  logic                                         M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]                    M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]                  M_AXI_WSTRB,
  output logic                                         M_AXI_WVALID,
  input  logic                                         M_AXI_WREADY,
  input  logic [1:0]                                   M_AXI_BRESP,
  input  logic                                         M_AXI_BVALID,
  output logic                                         M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]                    M_AXI_ARADDR,
  output logic [2:0]                                   M_AXI_ARPROT,
  output logic                                         M_AXI_ARVALID,
  input  logic                                         M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]                    M_AXI_RDATA,
  input  logic [1:0]                                   M_AXI_RRESP,
  input  logic                                         M_AXI_RVALID,
  output logic                                         M_AXI_RREADY
);

  localparam int unsigned A = AXI_ADDR_WIDTH;
  localparam int unsigned D = AXI_DATA_WIDTH;

  typedef enum logic [1:0] {W_IDLE, W_XFER, W_RESP} wstate_e;
  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} rstate_e;

  // AMCI_MOSI fields, LSB first: waddr, wdata, raddr, write, read
  logic [A-1:0] w_waddr;
  logic [D-1:0] w_wdata;
  logic [A-1:0] w_raddr;
  logic         w_write;
  logic         w_read;

  assign w_waddr = AMCI_MOSI[A-1:0];
  assign w_wdata = AMCI_MOSI[A+D-1:A];
  assign w_raddr = AMCI_MOSI[2*A+D-1:A+D];
  assign w_write = AMCI_MOSI[2*A+D];
  assign w_read  = AMCI_MOSI[2*A+D+1];

  wstate_e      r_wstate, w_wstate_nxt;
  logic         r_aw_done, w_aw_done_nxt;
  logic         r_w_done, w_w_done_nxt;
  logic [A-1:0] r_awaddr, w_awaddr_nxt;
  logic [D-1:0] r_wdata, w_wdata_nxt;
  logic [1:0]   r_wresp, w_wresp_nxt;

  rstate_e      r_rstate, w_rstate_nxt;
  logic [A-1:0] r_araddr, w_araddr_nxt;
  logic [D-1:0] r_rdata, w_rdata_nxt;
  logic [1:0]   r_rresp, w_rresp_nxt;

  logic         w_widle;
  logic         w_ridle;

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_wstate  <= W_IDLE;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wresp   <= 2'b00;
    end else begin
      r_wstate  <= w_wstate_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
      r_awaddr  <= w_awaddr_nxt;
      r_wdata   <= w_wdata_nxt;
      r_wresp   <= w_wresp_nxt;
    end
  end

  // AW and W complete independently; W_RESP waits until both have handshaken.
  always_comb begin
    w_wstate_nxt  = r_wstate;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    w_awaddr_nxt  = r_awaddr;
    w_wdata_nxt   = r_wdata;
    w_wresp_nxt   = r_wresp;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    w_widle       = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        w_widle = 1'b1;
        if (w_write) begin
          w_wstate_nxt  = W_XFER;
          w_awaddr_nxt  = w_waddr;
          w_wdata_nxt   = w_wdata;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      W_XFER: begin
        M_AXI_AWVALID = ~r_aw_done;
        M_AXI_WVALID  = ~r_w_done;
        w_aw_done_nxt = r_aw_done | M_AXI_AWREADY;
        w_w_done_nxt  = r_w_done | M_AXI_WREADY;
        if (w_aw_done_nxt && w_w_done_nxt) begin
          w_wstate_nxt  = W_RESP;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end
      end
      W_RESP: begin
        M_AXI_BREADY = 1'b1;
        if (M_AXI_BVALID) begin
          w_wstate_nxt = W_IDLE;
          w_wresp_nxt  = M_AXI_BRESP;
        end
      end
      default: begin
        w_wstate_nxt = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_rstate <= R_IDLE;
      r_araddr <= '0;
      r_rdata  <= '0;
      r_rresp  <= 2'b00;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_araddr <= w_araddr_nxt;
      r_rdata  <= w_rdata_nxt;
      r_rresp  <= w_rresp_nxt;
    end
  end

  always_comb begin
    w_rstate_nxt  = r_rstate;
    w_araddr_nxt  = r_araddr;
    w_rdata_nxt   = r_rdata;
    w_rresp_nxt   = r_rresp;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    w_ridle       = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        w_ridle = 1'b1;
        if (w_read) begin
          w_rstate_nxt = R_ADDR;
          w_araddr_nxt = w_raddr;
        end
      end
      R_ADDR: begin
        M_AXI_ARVALID = 1'b1;
        if (M_AXI_ARREADY) begin
          w_rstate_nxt = R_DATA;
        end
      end
      R_DATA: begin
        M_AXI_RREADY = 1'b1;
        if (M_AXI_RVALID) begin
          w_rstate_nxt = R_IDLE;
          w_rdata_nxt  = M_AXI_RDATA;
          w_rresp_nxt  = M_AXI_RRESP;
        end
      end
      default: begin
        w_rstate_nxt = R_IDLE;
      end
    endcase
  end

  assign M_AXI_AWADDR = r_awaddr;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_WDATA  = r_wdata;
  assign M_AXI_WSTRB  = '1;
  assign M_AXI_ARADDR = r_araddr;
  assign M_AXI_ARPROT = 3'b000;

  assign AMCI_MISO = {r_rresp, r_wresp, w_ridle, w_widle, r_rdata};

endmodule

// File: tb/tb_amci_axi4lite_master.sv
// Bench for amci_axi4lite_master: delay-programmable slave, vector table and scoreboard queues.
module tb_amci_axi4lite_master;

  localparam int D = 32;
  localparam int A = 32;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic         write, read;
  logic [A-1:0] waddr, raddr;
  logic [D-1:0] wdata;
  logic [2*A+D+1:0] mosi;
  logic [D+5:0] miso;
  assign mosi = {read, write, raddr, wdata, waddr};

  logic [D-1:0] rdata_o;
  logic         widle, ridle;
  logic [1:0]   wresp, rresp;
  assign rdata_o = miso[D-1:0];
  assign widle   = miso[D];
  assign ridle   = miso[D+1];
  assign wresp   = miso[D+3:D+2];
  assign rresp   = miso[D+5:D+4];

  logic [A-1:0]   awaddr, araddr;
  logic [2:0]     awprot, arprot;
  logic           awvalid, awready, wvalid, wready, bvalid, bready;
  logic           arvalid, arready, rvalid, rready;
  logic [D-1:0]   m_wdata, s_rdata;
  logic [D/8-1:0] wstrb;
  logic [1:0]     s_bresp, s_rresp;

  amci_axi4lite_master #(.AXI_DATA_WIDTH(D), .AXI_ADDR_WIDTH(A)) dut (
    .CLK(clk), .RESETN(rstn), .AMCI_MOSI(mosi), .AMCI_MISO(miso),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid),
    .M_AXI_AWREADY(awready), .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(wstrb),
    .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready), .M_AXI_BRESP(s_bresp),
    .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready), .M_AXI_ARADDR(araddr),
    .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(rvalid),
    .M_AXI_RREADY(rready)
  );

  // Slave: each channel accepts/answers after a programmable number of wait cycles.
  int aw_dly, w_dly, b_dly, ar_dly, r_dly;
  int aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
  assign awready = awvalid && (aw_cnt >= aw_dly);
  assign wready  = wvalid  && (w_cnt  >= w_dly);
  assign bvalid  = bready  && (b_cnt  >= b_dly);
  assign arready = arvalid && (ar_cnt >= ar_dly);
  assign rvalid  = rready  && (r_cnt  >= r_dly);

  always @(posedge clk) begin
    if (!rstn) begin
      aw_cnt <= 0; w_cnt <= 0; b_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid  && !wready)  ? w_cnt  + 1 : 0;
      b_cnt  <= (bready  && !bvalid)  ? b_cnt  + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      r_cnt  <= (rready  && !rvalid)  ? r_cnt  + 1 : 0;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: got an event, expected none", name);
  endtask

  typedef struct {
    logic [A-1:0] addr;
    logic [D-1:0] data;
    logic [1:0]   resp;
  } exp_t;
  exp_t wq[$];
  exp_t rq[$];

  int   aw_hs_n = 0, w_hs_n = 0, ar_hs_n = 0, order_viol = 0;
  logic widle_q = 1'b1, ridle_q = 1'b1;

  // Scoreboard monitor: checks handshake payloads and pops on completion.
  always @(negedge clk) begin
    widle_q <= widle;
    ridle_q <= ridle;
    if (rstn) begin
      if (awvalid && awready) begin
        aw_hs_n <= aw_hs_n + 1;
        if (wq.size() == 0) unexpected("aw_handshake");
        else check("awaddr", awaddr, wq[0].addr);
      end
      if (wvalid && wready) begin
        w_hs_n <= w_hs_n + 1;
        if (wq.size() == 0) unexpected("w_handshake");
        else check("wdata", m_wdata, wq[0].data);
      end
      if (arvalid && arready) begin
        ar_hs_n <= ar_hs_n + 1;
        if (rq.size() == 0) unexpected("ar_handshake");
        else check("araddr", araddr, rq[0].addr);
      end
      if (bready && (awvalid || wvalid)) order_viol <= order_viol + 1;
      if (widle && !widle_q) begin
        if (wq.size() == 0) unexpected("write_completion");
        else begin
          check("wresp", wresp, wq[0].resp);
          void'(wq.pop_front());
        end
      end
      if (ridle && !ridle_q) begin
        if (rq.size() == 0) unexpected("read_completion");
        else begin
          check("rdata", rdata_o, rq[0].data);
          check("rresp", rresp, rq[0].resp);
          void'(rq.pop_front());
        end
      end
    end
  end

  int aw_cyc_n = 0, w_cyc_n = 0, ar_cyc_n = 0;
  always @(negedge clk) begin
    if (awvalid) aw_cyc_n <= aw_cyc_n + 1;
    if (wvalid)  w_cyc_n  <= w_cyc_n + 1;
    if (arvalid) ar_cyc_n <= ar_cyc_n + 1;
  end

  typedef struct {
    bit           is_wr;
    logic [A-1:0] addr;
    logic [D-1:0] data;
    int           a_dly;
    int           d_dly;
    int           rsp_dly;
    logic [1:0]   resp;
    int           exp_lat;
    int           exp_acyc;
    int           exp_dcyc;
  } vec_t;

  task automatic run_vec(input vec_t v);
    exp_t e;
    int   n, a0, d0;
    @(negedge clk);
    e.addr = v.addr; e.data = v.data; e.resp = v.resp;
    a0 = v.is_wr ? aw_cyc_n : ar_cyc_n;
    d0 = w_cyc_n;
    if (v.is_wr) begin
      waddr = v.addr; wdata = v.data; s_bresp = v.resp;
      aw_dly = v.a_dly; w_dly = v.d_dly; b_dly = v.rsp_dly;
      wq.push_back(e);
      write = 1'b1;
    end else begin
      raddr = v.addr; s_rdata = v.data; s_rresp = v.resp;
      ar_dly = v.a_dly; r_dly = v.rsp_dly;
      rq.push_back(e);
      read = 1'b1;
    end
    @(negedge clk);
    write = 1'b0;
    read  = 1'b0;
    n = 1;
    check("busy_after_pulse", v.is_wr ? widle : ridle, 1'b0);
    while (!(v.is_wr ? widle : ridle) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("pulse_to_idle", n, v.exp_lat);
    #1;
    if (v.is_wr) begin
      check("awvalid_cycles", aw_cyc_n - a0, v.exp_acyc);
      check("wvalid_cycles", w_cyc_n - d0, v.exp_dcyc);
    end else begin
      check("arvalid_cycles", ar_cyc_n - a0, v.exp_acyc);
    end
  endtask

  vec_t vecs[7];
  vec_t post;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int   n, base_aw;
    exp_t e;
    //                 wr  addr          data          a  d  rsp resp lat acyc dcyc
    vecs[0] = '{1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 0, 0, 0, 2'd0, 3, 1, 1};
    vecs[1] = '{1'b0, 32'h0000_2004, 32'h1234_5678, 4, 0, 0, 2'd2, 7, 5, 0};
    vecs[2] = '{1'b1, 32'h0000_3008, 32'hA5A5_5A5A, 3, 0, 0, 2'd3, 6, 4, 1};
    vecs[3] = '{1'b1, 32'h0000_300C, 32'h0F0F_0F0F, 0, 2, 1, 2'd1, 6, 1, 3};
    vecs[4] = '{1'b0, 32'h0000_2010, 32'hCAFE_F00D, 0, 0, 0, 2'd0, 3, 1, 0};
    vecs[5] = '{1'b0, 32'h0000_2014, 32'h8765_4321, 1, 0, 3, 2'd3, 7, 2, 0};
    vecs[6] = '{1'b1, 32'h0000_3010, 32'h1357_9BDF, 2, 2, 0, 2'd2, 5, 3, 3};
    post    = '{1'b1, 32'h0000_9000, 32'h55AA_55AA, 0, 0, 0, 2'd2, 3, 1, 1};

    aw_dly = 0; w_dly = 0; b_dly = 0; ar_dly = 0; r_dly = 0;
    s_bresp = 2'd0; s_rresp = 2'd0; s_rdata = '0;

    // Reset held with both command bits asserted
    rstn = 1'b0;
    write = 1'b1; read = 1'b1;
    waddr = 32'hFFFF_0000; wdata = 32'h0123_4567; raddr = 32'hFFFF_0004;
    repeat (3) @(negedge clk);
    check("rst_valid_ready", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("rst_idles", {widle, ridle}, 2'b11);
    check("rst_resps", {wresp, rresp}, 4'b0);
    check("rst_rdata", rdata_o, '0);
    check("rst_addr_data", {awaddr, m_wdata, araddr}, '0);
    check("const_prot_strb", {awprot, arprot, wstrb}, {6'b0, 4'hF});
    write = 1'b0; read = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_after_reset", {widle, ridle, awvalid, arvalid}, 4'b1100);

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Second write pulse while busy, with a concurrent read
    @(negedge clk);
    base_aw = aw_hs_n;
    aw_dly = 2; w_dly = 2; b_dly = 2; s_bresp = 2'd1;
    waddr = 32'h0000_4000; wdata = 32'h1111_2222;
    e.addr = waddr; e.data = wdata; e.resp = 2'd1;
    wq.push_back(e);
    write = 1'b1;
    @(negedge clk);
    write = 1'b0;
    @(negedge clk);
    waddr = 32'h0000_5000; wdata = 32'h3333_4444; write = 1'b1;
    ar_dly = 0; r_dly = 0; s_rresp = 2'd2; s_rdata = 32'h0BAD_F00D;
    raddr = 32'h0000_6000;
    e.addr = raddr; e.data = s_rdata; e.resp = 2'd2;
    rq.push_back(e);
    read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    n = 1;
    while (!ridle && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("concurrent_read_latency", n, 3);
    check("write_busy_at_read_done", widle, 1'b0);
    n = 0;
    while (!widle && n < 60) begin
      @(negedge clk);
      n++;
    end
    repeat (10) @(negedge clk);
    check("ignored_write_aw_count", aw_hs_n - base_aw, 1);
    check("write_idle_after_busy", widle, 1'b1);

    // Reset while write in W_RESP and read in R_ADDR
    @(negedge clk);
    aw_dly = 0; w_dly = 0; b_dly = 20; ar_dly = 20;
    waddr = 32'h0000_7000; wdata = 32'h7777_7777; raddr = 32'h0000_8000;
    e.addr = waddr; e.data = wdata; e.resp = 2'd0;
    wq.push_back(e);
    e.addr = raddr; e.data = '0;
    rq.push_back(e);
    write = 1'b1; read = 1'b1;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    @(negedge clk);
    check("mid_bready", bready, 1'b1);
    check("mid_arvalid", arvalid, 1'b1);
    #2 rstn = 1'b0;
    #1;
    check("async_valid_ready", {awvalid, wvalid, bready, arvalid, rready}, 5'b0);
    check("async_idles", {widle, ridle}, 2'b11);
    check("async_resps", {wresp, rresp}, 4'b0);
    check("async_rdata", rdata_o, '0);
    check("async_addr_data", {awaddr, m_wdata, araddr}, '0);
    wq.delete();
    rq.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    run_vec(post);

    repeat (3) @(negedge clk);
    check("bready_after_aw_w", order_viol, 0);
    check("queues_drained", wq.size() + rq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
